tinyqv_shift_seq: RTL and testbench
===================================

Name: tinyqv_shift_seq

Overview:
- Nibble-serial shift unit: consumes operand A as 4-bit slices LSB-first, and emits the shifted result as 4-bit slices LSB-first.
- Sits between the nibble-serial register-file read path and the writeback path. It is the receiving end of the slice stream that the combinational shifter normally gets fully parallel.
- Capture and result buffers are separate, so word N+1 can be captured while word N is emitted.

Parameters:
- XLEN, 32, operand width. Supported values are 16 and 32. Slice count NIB = XLEN/4. Shift-amount width SW = clog2(XLEN).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- in_start  in  1  marks slice 0 of a new word. Only valid together with in_valid.
- in_valid  in  1  a_nib is valid this cycle.
- op  in  2  shift operation, sampled at in_start: 00 SLL, 01 SRL, 11 SRA, 10 see Optional Feature.
- shamt  in  SW  shift amount, sampled at in_start.
- a_nib  in  4  operand slice.
- out_valid  out  1  out_nib is valid this cycle.
- out_last  out  1  high with the final result slice.
- out_nib  out  4  result slice, LSB-first.

Behaviour:
- Reset (rstn low, asynchronous): out_valid=0, out_last=0, out_nib=0, capture count=0, capture buffer and result buffer cleared, capture state IDLE. Deassertion is taken synchronously.
- Capture FSM states: IDLE and CAPT.
  - in_start & in_valid: store slice 0, latch op and shamt, count=1, go to CAPT. This applies in any state; in CAPT it discards the partial word (restart).
  - CAPT with in_valid & !in_start: store slice at position count, count+1.
  - CAPT with in_valid low: stall, hold all state. Gaps are allowed.
  - in_valid without in_start while IDLE: ignored.
  - When slice NIB-1 is stored: the next edge loads the result buffer with the full shifted word, the emit counter is set to 0, and the FSM returns to IDLE.
- Arithmetic on the full XLEN word:
  - SLL = A<<shamt, SRL = A>>shamt, SRA = signed(A)>>>shamt.
  - shamt=0 returns A unchanged.
  - SRA fills with bit XLEN-1.
- Emit:
  - Starts the cycle after the load. out_valid is high for exactly NIB consecutive cycles with no stall and no ready input.
  - out_nib is result[4k+:4] on cycle k. out_last is high on k=NIB-1 only.
  - out_nib is 0 when out_valid is low.
- Latency, gap-free input: in_start at cycle 0, slice k at cycle k. out_valid runs cycles NIB..2*NIB-1.
- Back-to-back: in_start at cycle NIB (the first emit cycle of the previous word) produces seamless output at 2*NIB..3*NIB-1 with out_valid never dropping. A capture cannot complete before the previous emit finishes, so the result buffer never needs a hold.
- Restart mid-capture has no effect on an emit in progress.
- Reset mid-emit or mid-capture aborts both. out_valid=0 immediately (asynchronous).

Optional Feature:
- Macro: TINYQV_SHIFT_ROR_EN.
- Defined: op=10 is rotate right, result = (A>>shamt)|(A<<(XLEN-shamt)), with shamt=0 giving A.
- Undefined: op=10 behaves exactly as SRL, and no rotate logic is synthesized.

Test Plan:
- SLL, A=0x12345678, shamt=4, gap-free from cycle 0 -> out_valid cycles 8..15, out_nib 0,8,7,6,5,4,3,2, out_last at cycle 15.
- SRA, A=0x80000000, shamt=31 -> all slices F (0xFFFFFFFF). SRL with the same inputs -> 1,0,0,0,0,0,0,0 (0x00000001).
- Back-to-back: word1 SRL 0xF0000000 shamt=28, word2 SLL 0x00000001 shamt=31 with in_start at cycle 8 -> cycles 8..15 give F,0,...,0; cycles 16..23 give 0,...,0,8; out_valid continuously high 8..23.
- Gaps and restart: in_start with slices 0..3, in_valid low 3 cycles, then in_start again with A=0x0000000A, shamt=0, SLL -> a single 8-slice output A,0,0,0,0,0,0,0 and no output from the aborted word.
- rstn low on the 4th emit cycle -> out_valid/out_nib zero immediately. After release, no further slices until a new in_start.
- With TINYQV_SHIFT_ROR_EN: op=10, A=0x12345678, shamt=8 -> 0x78123456. Without it, the same stimulus -> 0x00123456.

Source files
------------

// File: rtl/tinyqv_shift_seq.sv
// Nibble-serial shift unit: captures A LSB-first, emits the shifted word LSB-first.
// Define TINYQV_SHIFT_ROR_EN to make op=10 a rotate right (otherwise it is SRL).
module tinyqv_shift_seq #(
  parameter  int XLEN = 32,
  localparam int NIB  = XLEN / 4,
  localparam int SW   = $clog2(XLEN)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_start,
  input  logic          in_valid,
  input  logic [1:0]    op,
  input  logic [SW-1:0] shamt,
  input  logic [3:0]    a_nib,
  output logic          out_valid,
  output logic          out_last,
  output logic [3:0]    out_nib
);

  localparam int CW = $clog2(NIB);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CAPT = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] ecnt;
  logic          emit;
  logic [1:0]    cap_op;
  logic [SW-1:0] cap_sh;
  logic [XLEN-1:0] cap_buf;
  logic [XLEN-1:0] res_buf;
  logic [XLEN-1:0] word;
  logic [XLEN-1:0] shifted;
  logic          start;
  logic          last_in;

  assign start   = in_valid & in_start;
  assign last_in = (state == CAPT) & in_valid & ~in_start
                 & (cnt == CW'(NIB - 1));

  // The final slice is folded in directly so the result loads on its own edge.
  always_comb begin
    word             = cap_buf;
    word[XLEN-1 -: 4] = a_nib;
  end

`ifdef TINYQV_SHIFT_ROR_EN
  logic [2*XLEN-1:0] dbl;
  assign dbl = {word, word} >> cap_sh;
`endif

  always_comb begin
    shifted = word >> cap_sh;
    unique case (1'b1)
      cap_op == 2'b00: shifted = word << cap_sh;
      cap_op == 2'b01: shifted = word >> cap_sh;
      cap_op == 2'b11: shifted = $unsigned($signed(word) >>> cap_sh);
`ifdef TINYQV_SHIFT_ROR_EN
      default:         shifted = dbl[XLEN-1:0];
`else
      default:         shifted = word >> cap_sh;
`endif
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      cap_op  <= '0;
      cap_sh  <= '0;
      cap_buf <= '0;
    end else if (start) begin
      state        <= CAPT;
      cnt          <= CW'(1);
      cap_op       <= op;
      cap_sh       <= shamt;
      cap_buf[3:0] <= a_nib;
    end else if (state == CAPT && in_valid) begin
      cap_buf[{cnt, 2'b00} +: 4] <= a_nib;
      if (last_in) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      emit    <= 1'b0;
      ecnt    <= '0;
      res_buf <= '0;
    end else if (last_in) begin
      emit    <= 1'b1;
      ecnt    <= '0;
      res_buf <= shifted;
    end else if (emit) begin
      ecnt <= ecnt + CW'(1);
      if (ecnt == CW'(NIB - 1)) emit <= 1'b0;
    end
  end

  assign out_valid = emit;
  assign out_last  = emit & (ecnt == CW'(NIB - 1));
  assign out_nib   = emit ? res_buf[{ecnt, 2'b00} +: 4] : 4'h0;

endmodule

// File: tb/tb_tinyqv_shift_seq.sv
// Scoreboard bench for tinyqv_shift_seq: random words, gaps, restarts, reset abort.
// Honours TINYQV_SHIFT_ROR_EN for the expected op=10 behaviour.
module tb_tinyqv_shift_seq;

  localparam int XLEN = 32;
  localparam int NIB  = XLEN / 4;
  localparam int SW   = $clog2(XLEN);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_start = 1'b0;
  logic          in_valid = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [SW-1:0] shamt = '0;
  logic [3:0]    a_nib = 4'h0;
  logic          out_valid;
  logic          out_last;
  logic [3:0]    out_nib;

  tinyqv_shift_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rstn(rstn), .in_start(in_start), .in_valid(in_valid),
    .op(op), .shamt(shamt), .a_nib(a_nib),
    .out_valid(out_valid), .out_last(out_last), .out_nib(out_nib)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] w;
    int              st;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Shift expressed as repeated halving/doubling of an integer.
  function automatic logic [XLEN-1:0] ref_shift(input logic [1:0] o,
                                                input int s,
                                                input logic [XLEN-1:0] a);
    longint unsigned x   = a;
    longint unsigned top = 64'd2147483648;
    longint unsigned md  = top * 2;
    for (int i = 0; i < s; i++) begin
      case (o)
        2'b00: x = (x * 2) % md;
        2'b01: x = x / 2;
        2'b11: x = x / 2 + ((x >= top) ? top : 0);
`ifdef TINYQV_SHIFT_ROR_EN
        default: x = x / 2 + (x % 2) * top;
`else
        default: x = x / 2;
`endif
      endcase
    end
    return x[XLEN-1:0];
  endfunction

  task automatic send(input logic [1:0] o, input int s,
                      input logic [XLEN-1:0] a, input int gap_pct,
                      input int n, input bit push);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        for (int g = 0; g < 40 && $urandom_range(99) < gap_pct; g++) begin
          in_valid = 1'b0;
          in_start = 1'b0;
          a_nib    = 4'($urandom);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_start = (k == 0);
      a_nib    = a[4*k +: 4];
      op       = (k == 0) ? o : 2'($urandom);
      shamt    = (k == 0) ? SW'(s) : SW'($urandom);
      if (k == NIB - 1 && push) begin
        e.w  = ref_shift(o, s, a);
        e.st = cyc + 1;
        q.push_back(e);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && !out_valid) done = 1'b1;
    end
    chk(name, XLEN'(done), XLEN'(1));
  endtask

  // Monitor: pops one expected word per emit burst and checks every slice.
  exp_t cur;
  bit   have = 1'b0;
  int   k = 0;
  always @(negedge clk) begin
    if (!mon_en) begin
      k    = 0;
      have = 1'b0;
    end else if (out_valid) begin
      if (k == 0) begin
        have = (q.size() != 0);
        if (!have) begin
          errors++;
          checks++;
          $display("FAIL unexpected_output act=%h exp=none cyc=%0d",
                   out_nib, cyc);
        end else begin
          cur = q.pop_front();
          chk("emit_start_cycle", XLEN'(cyc), XLEN'(cur.st));
        end
      end
      if (have) begin
        chk("out_nib", XLEN'(out_nib), XLEN'(cur.w[4*k +: 4]));
        chk("out_last", XLEN'(out_last), XLEN'(k == NIB - 1));
      end
      k = (k == NIB - 1) ? 0 : k + 1;
    end else begin
      chk("idle_nib", XLEN'(out_nib), XLEN'(0));
      chk("idle_last", XLEN'(out_last), XLEN'(0));
      if (k != 0) chk("burst_gap", XLEN'(k), XLEN'(0));
      k = 0;
    end
  end

  initial begin
    bit seen;
    #2;
    chk("rst_valid", XLEN'(out_valid), XLEN'(0));
    chk("rst_last", XLEN'(out_last), XLEN'(0));
    chk("rst_nib", XLEN'(out_nib), XLEN'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    send(2'b00, 4, 32'h12345678, 0, NIB, 1);
    send(2'b11, 31, 32'h80000000, 0, NIB, 1);
    send(2'b01, 31, 32'h80000000, 0, NIB, 1);
    send(2'b01, 28, 32'hF0000000, 0, NIB, 1);
    send(2'b00, 31, 32'h00000001, 0, NIB, 1);
    send(2'b00, 0, 32'($urandom), 0, 4, 0);
    repeat (3) begin
      a_nib = 4'($urandom);
      @(posedge clk); #1;
    end
    send(2'b00, 0, 32'h0000000A, 0, NIB, 1);
    send(2'b10, 8, 32'h12345678, 0, NIB, 1);
    send(2'b10, 0, 32'hDEADBEEF, 0, NIB, 1);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) == 0)
        send(2'($urandom), $urandom_range(XLEN - 1), 32'($urandom),
             $urandom_range(50), $urandom_range(1, NIB - 1), 0);
      send(2'($urandom), $urandom_range(XLEN - 1), 32'($urandom),
           (i % 3 == 0) ? 0 : $urandom_range(60), NIB, 1);
      if ($urandom_range(4) == 0) begin
        for (int j = 0; j < $urandom_range(1, 3); j++) begin
          in_valid = 1'b1;
          in_start = 1'b0;
          a_nib    = 4'($urandom);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
    end
    drain("drain_random");

    mon_en = 1'b0;
    send(2'b00, 0, 32'hCAFEF00D, 0, NIB, 0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("abort_word_emits", XLEN'(seen), XLEN'(1));
    repeat (3) begin @(posedge clk); #1; end
    rstn = 1'b0;
    #1;
    chk("async_rst_valid", XLEN'(out_valid), XLEN'(0));
    chk("async_rst_nib", XLEN'(out_nib), XLEN'(0));
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 2 * NIB; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", XLEN'(out_valid), XLEN'(0));
    end
    @(posedge clk); #1;
    q.delete();
    mon_en = 1'b1;
    send(2'b11, 5, 32'h9ABCDEF0, 20, NIB, 1);
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
